// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin sharing of one req/gnt/rvalid device port
// between NrHosts requesters. The grant is locked across device stalls and
// the grant order is kept in an ID FIFO so in-order responses find their host.
module bus_host_arbiter #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],
    output logic                      dev_req_o,
    input  logic                      dev_gnt_i,
    output logic [AddressWidth-1:0]   dev_addr_o,
    output logic                      dev_we_o,
    output logic [DataWidth/8-1:0]    dev_be_o,
    output logic [DataWidth-1:0]      dev_wdata_o,
    input  logic                      dev_rvalid_i,
    input  logic [DataWidth-1:0]      dev_rdata_i,
    input  logic                      dev_err_i,
    output logic                      unexp_rsp_o
);

    localparam int IdW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [IdW-1:0]  LastId  = IdW'(NrHosts - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdW-1:0]  lock_id_q, lock_id_d;
    logic [IdW-1:0]  fifo_q [MaxOutstanding];
    logic [IdW-1:0]  fifo_d [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [IdW-1:0]  winner;
    logic            any_req;
    logic            found;
    int              scan_idx;
    logic            handshake;
    logic            pop;
    logic [IdW-1:0]  head_id;

    // Winner: locked host if it still requests, else first requester from rr_ptr upward.
    always_comb begin
        any_req  = 1'b0;
        found    = 1'b0;
        scan_idx = 0;
        winner   = rr_ptr_q;
        for (int k = 0; k < NrHosts; k++) begin
            if (host_req_i[k]) any_req = 1'b1;
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NrHosts) scan_idx = scan_idx - NrHosts;
            if (!found && host_req_i[scan_idx]) begin
                found  = 1'b1;
                winner = IdW'(scan_idx);
            end
        end
        if (lock_q && host_req_i[lock_id_q]) winner = lock_id_q;
    end

    // Device request, host grants and response routing (all combinational).
    always_comb begin
        dev_req_o   = any_req && (cnt_q < MaxCnt);
        handshake   = dev_req_o && dev_gnt_i;
        head_id     = fifo_q[rd_ptr_q];
        pop         = dev_rvalid_i && (cnt_q != '0);
        unexp_rsp_o = dev_rvalid_i && (cnt_q == '0);
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (dev_req_o) begin
            dev_addr_o  = host_addr_i[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[winner];
            dev_wdata_o = host_wdata_i[winner];
        end
        for (int i = 0; i < NrHosts; i++) begin
            host_gnt_o[i]    = handshake && (winner == IdW'(i));
            host_rvalid_o[i] = pop && (head_id == IdW'(i));
            host_rdata_o[i]  = dev_rvalid_i ? dev_rdata_i : '0;
            host_err_o[i]    = dev_rvalid_i && dev_err_i;
        end
    end

    // Next state: pointer advance, grant lock, ID FIFO push/pop and occupancy.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (handshake) begin
            rr_ptr_d         = (winner == LastId) ? '0 : winner + 1'b1;
            lock_d           = 1'b0;
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end else if (dev_req_o) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end else if (lock_q && !host_req_i[lock_id_q]) begin
            // Locked host withdrew its request mid-stall; drop the lock.
            lock_d = 1'b0;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        case ({handshake, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            fifo_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/bus_host_arbiter.md
# bus_host_arbiter

Round-robin arbiter that shares one device port (e.g. the simple-system RAM data port or a crossbar device slot) between `NrHosts` requesters speaking the core's req/gnt/rvalid protocol. It selects one host per cycle, holds that grant stable across device back-pressure, and records the granting order in an ID FIFO so in-order device responses return to the correct host. It sits between host ports (core data, debug module, DMA) and a single memory or device.

## Interface
- `NrHosts`, 2: number of requesters (2..8).
- `DataWidth`, 32: data width.
- `AddressWidth`, 32: address width.
- `MaxOutstanding`, 2: maximum accepted-but-unanswered requests (1..8); also the ID FIFO depth.

Ports (`[N]` marks an unpacked array of size `NrHosts`):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `host_req_i[N]` in 1: host request.
- `host_gnt_o[N]` out 1: request accepted this cycle.
- `host_addr_i[N]` in AddressWidth: address.
- `host_we_i[N]` in 1: write enable.
- `host_be_i[N]` in DataWidth/8: byte enables.
- `host_wdata_i[N]` in DataWidth: write data.
- `host_rvalid_o[N]` out 1: response valid for that host.
- `host_rdata_o[N]` out DataWidth: response data, the same value broadcast to all hosts.
- `host_err_o[N]` out 1: response error, the same value broadcast to all hosts.
- `dev_req_o` out 1: device request.
- `dev_gnt_i` in 1: device accepts the request.
- `dev_addr_o`, `dev_we_o`, `dev_be_o`, `dev_wdata_o` out: the winner's fields.
- `dev_rvalid_i` in 1: device response, in order.
- `dev_rdata_i` in DataWidth: device response data.
- `dev_err_i` in 1: device response error.
- `unexp_rsp_o` out 1: one-cycle pulse when `dev_rvalid_i` arrives while the ID FIFO is empty.

## Operation
- **State**
  - `rr_ptr`: width clog2(NrHosts), reset 0.
  - `lock_q`, `lock_id_q`: grant lock flag and locked host index, reset 0.
  - ID FIFO: `MaxOutstanding` entries of clog2(NrHosts) bits, with read/write pointers.
  - `cnt_q`: occupancy counter, width clog2(MaxOutstanding+1), reset 0.
- **Winner selection**
  - If `lock_q` is set and `host_req_i[lock_id_q]` is high, the winner is `lock_id_q`.
  - Otherwise the winner is the first requesting host scanning upward from `rr_ptr` with wrap-around modulo `NrHosts`.
- **Issue**
  - `dev_req_o` = (any eligible request) AND `cnt_q < MaxOutstanding`.
  - The dev fields mux the winner's inputs. When `dev_req_o` is 0 they are driven to 0.
- **Handshake** (`dev_req_o & dev_gnt_i`)
  - `host_gnt_o[winner]` = 1 and every other `host_gnt_o` = 0.
  - The winner index is pushed into the ID FIFO.
  - `rr_ptr` <= (winner+1) mod `NrHosts`.
  - `lock_q` <= 0.
- **Stall** (`dev_req_o & !dev_gnt_i`)
  - `lock_q` <= 1 and `lock_id_q` <= winner, so the grant stays stable and re-arbitration is blocked.
- **Lock release**
  - If the locked host drops `host_req_i`, which is a protocol violation, the lock is ignored and cleared next cycle.
- **Response** (`dev_rvalid_i` with FIFO non-empty)
  - `host_rvalid_o[head]` = 1 and the FIFO pops.
  - `host_rdata_o` = `dev_rdata_i` and `host_err_o` = `dev_err_i` on all hosts.
- **Response with FIFO empty**
  - No `host_rvalid_o` is asserted and `unexp_rsp_o` = 1.
  - The counter does not underflow.
- **Counter update**
  - Push and pop in the same cycle leave `cnt_q` unchanged.
  - Push only increments; pop only decrements.
- **FIFO full** (`cnt_q == MaxOutstanding`)
  - `dev_req_o` = 0 even if a response pops in that same cycle; there is no bypass.
  - Issue resumes the following cycle.
- **Reset mid-operation**
  - The FIFO, counter, lock and pointer clear immediately.
  - In-flight responses arriving after reset deassertion are reported via `unexp_rsp_o` and dropped.

## Timing
- Request path is combinational: from `host_req_i` to `dev_req_o`, and from `dev_gnt_i` to `host_gnt_o`, in the same cycle.
- Response path is combinational: from `dev_rvalid_i` to `host_rvalid_o` in the same cycle, with zero added latency.
- `rr_ptr`, the lock, the FIFO and `cnt_q` update on the rising clock edge after the handshake.
- Reset values:
  - All `host_gnt_o` = 0, `host_rvalid_o` = 0, `host_rdata_o` = 0, `host_err_o` = 0.
  - `dev_req_o` = 0 and all dev fields = 0.
  - `unexp_rsp_o` = 0.
- Throughput: one grant per cycle while `cnt_q < MaxOutstanding`.

## Test plan
- **Fairness:** NrHosts=2, MaxOutstanding=2, both hosts hold req continuously, `dev_gnt_i`=1, `dev_rvalid_i` one cycle after each grant. Required grant order: H0, H1, H0, H1. Each `host_rvalid_o` matches its own grant.
- **Stall lock:** H1 alone requests addr 0x0010_0040 with `dev_gnt_i`=0 for 3 cycles, and H0 raises req in cycle 2. `dev_addr_o` stays 0x0010_0040 and `host_gnt_o[0]` stays 0 until H1 is granted in cycle 4. H0 is granted in cycle 5.
- **Full throttle:** `dev_rvalid_i` held low, H0 issues 2 grants. `dev_req_o` = 0 on the third cycle with `cnt_q`=2. A single rvalid with rdata 0xDEAD_BEEF is routed to H0. Issue resumes the next cycle.
- **Out-of-turn response ordering:** grants in order H1, H0. Responses 0x1111 then 0x2222 are delivered as `host_rvalid_o[1]` with 0x1111, then `host_rvalid_o[0]` with 0x2222.
- **Simultaneous push/pop:** with `cnt_q`=1, a new grant coincides with a response. `cnt_q` stays 1 and the FIFO head advances correctly.
- **Reset mid-flight:** with `cnt_q`=2, assert `rst_ni` low for 1 cycle, then pulse `dev_rvalid_i`. Required: `unexp_rsp_o`=1, all `host_rvalid_o`=0, `cnt_q`=0.
